message_assembler: RTL and testbench
====================================

MESSAGE_ASSEMBLER -- requirements
Module: message_assembler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the bus beat width in bits.
REQ-002 SHALL have parameter MSG_WIDTH, default 144 (16+128), the assembled message width in bits.
REQ-003 SHALL have parameter DEPTH, default 2, the number of output queue entries; it is a power of two and at least 1.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port nRST, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in$enq__ENA, input, 1 bit: the beat is valid.
REQ-007 SHALL have port in$enq$v, input, WIDTH bits: beat data.
REQ-008 SHALL have port in$enq$last, input, 1 bit: the final beat of a message.
REQ-009 SHALL have port in$enq__RDY, output, 1 bit: a beat is accepted.
REQ-010 SHALL have port out$enq__ENA, output, 1 bit: an assembled message is valid.
REQ-011 SHALL have port out$enq$v, output, MSG_WIDTH bits: the assembled message.
REQ-012 SHALL have port out$enq__RDY, input, 1 bit: the sink accepts the message.

Function
REQ-013 SHALL define N = ceil(MSG_WIDTH/WIDTH); with the defaults N = 5.
REQ-014 SHALL place beat k (k = 0 first) at message bits [k*WIDTH +: WIDTH].
- Bits above MSG_WIDTH-1 are dropped.
REQ-015 SHALL treat a beat as accepted only when in$enq__ENA and in$enq__RDY are both 1 in the same cycle.
REQ-016 SHALL drive in$enq__RDY = (queue not full) OR (state == DISCARD).
- in$enq__RDY depends on registered state only, with no combinational path from out$enq__RDY.
REQ-017 SHALL implement the states COLLECT and DISCARD, and hold a beat counter of clog2(N+1) bits.
REQ-018 In COLLECT, an accepted beat with last=0 and count < N-1 SHALL store the beat and increment the count.
REQ-019 In COLLECT, an accepted beat with last=1 SHALL push the message into the queue and reset the count to 0.
- Unreceived upper bits are zero-filled (short message).
REQ-020 In COLLECT, an accepted beat with last=0 and count == N-1 SHALL push the message, reset the count, and go to DISCARD (overrun).
REQ-021 In DISCARD, every accepted beat SHALL be dropped; a beat with last=1 returns the state to COLLECT.
REQ-022 A message SHALL appear at out$enq__ENA in the cycle after its completing beat is accepted, when the queue was empty (1-cycle latency).
REQ-023 SHALL drive out$enq__ENA = queue not empty and out$enq$v = queue head.
- A pop occurs when out$enq__ENA and out$enq__RDY are both 1.
- Order is FIFO.
REQ-024 A simultaneous push and pop SHALL leave the occupancy unchanged and both messages intact.
- When the queue is full, a same-cycle pop does not raise in$enq__RDY until the next cycle.
REQ-025 The assembly register SHALL be cleared after each push, so that no stale bits reach a later short message.
REQ-026 Read and write queue pointers SHALL wrap modulo DEPTH; a separate full/empty flag or an extra pointer bit distinguishes full from empty.

Reset
REQ-027 On nRST = 0, the block SHALL immediately clear state to COLLECT, count to 0, the assembly register to 0, and the queue to empty.
- Outputs become out$enq__ENA = 0, out$enq$v = 0 and in$enq__RDY = 1, which holds from the first cycle after release.
REQ-028 A reset during a partial message or DISCARD SHALL lose all partial data and queued data without error.

Configuration
REQ-029 With ADAPTER_ERRCNT_EN defined, the block SHALL add output err_count (16 bits).
- err_count increments by one per short message (last=1 with fewer than N beats) and per overrun entry into DISCARD.
- It saturates at 0xFFFF and resets to 0.
REQ-030 Without ADAPTER_ERRCNT_EN, the block SHALL omit the err_count port and its logic; all other behaviour is identical.

Verification
REQ-031 SHALL verify the nominal message.
- Stimulus: 5 beats 0x11111111..0x55555555, last on the 5th, out$enq__RDY = 1.
- Response: out$enq__ENA for 1 cycle, one cycle after beat 5, with out$enq$v[31:0] = 0x11111111 and [143:128] = 0x5555.
REQ-032 SHALL verify a short message.
- Stimulus: 2 beats 0xAAAAAAAA, 0xBBBBBBBB with last on the 2nd.
- Response: out$enq$v = {80'h0, 32'hBBBBBBBB, 32'hAAAAAAAA}; err_count = 1 when ADAPTER_ERRCNT_EN is defined.
REQ-033 SHALL verify an overrun.
- Stimulus: 7 beats with last only on the 7th.
- Response: one message built from beats 1-5 is emitted; beats 6-7 are dropped; err_count = 1; the next 5-beat message is assembled correctly.
REQ-034 SHALL verify backpressure.
- Stimulus: out$enq__RDY = 0, three back-to-back messages, DEPTH = 2.
- Response: in$enq__RDY = 0 after the 2nd push.
- Then raise out$enq__RDY: the messages are popped in order, and in$enq__RDY returns the cycle after the first pop.
REQ-035 SHALL verify reset mid-message.
- Stimulus: 3 beats, then nRST pulsed low, then a fresh 5-beat message.
- Response: only the fresh message is output, with no stale bits.

Source files
------------

// File: rtl/message_assembler.sv
// rtl/message_assembler.sv - packs WIDTH-bit beats into MSG_WIDTH-bit messages behind a DEPTH-entry queue.
// Optional feature: ADAPTER_ERRCNT_EN adds a saturating err_count output.
module message_assembler #(
  parameter int WIDTH     = 32,
  parameter int MSG_WIDTH = 144,
  parameter int DEPTH     = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 in_enq_ena,
  input  logic [WIDTH-1:0]     in_enq_v,
  input  logic                 in_enq_last,
  output logic                 in_enq_rdy,
  output logic                 out_enq_ena,
  output logic [MSG_WIDTH-1:0] out_enq_v,
  input  logic                 out_enq_rdy
`ifdef ADAPTER_ERRCNT_EN
  ,
  output logic [15:0]          err_count
`endif
);

  localparam int N  = (MSG_WIDTH + WIDTH - 1) / WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam int AW = N * WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DISCARD = 1'b1;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  logic [0:0]           r_state;
  logic [CW-1:0]        r_count;
  logic [AW-1:0]        r_asm;
  logic [MSG_WIDTH-1:0] r_q [DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [OW-1:0]        r_occ;

  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_collect;
  logic          w_at_last;
  logic          w_push;
  logic          w_pop;
  logic          w_overrun;
  logic          w_short;
  logic [AW-1:0] w_merged;
  int            w_base;

  assign w_full    = (r_occ == OCC_FULL);
  assign w_empty   = (r_occ == '0);
  assign w_accept  = in_enq_ena & in_enq_rdy;
  assign w_collect = w_accept & (r_state == COLLECT);
  assign w_at_last = (r_count == LAST_IDX);
  assign w_push    = w_collect & (in_enq_last | w_at_last);
  assign w_overrun = w_collect & ~in_enq_last & w_at_last;
  assign w_short   = w_collect & in_enq_last & ~w_at_last;
  assign w_pop     = ~w_empty & out_enq_rdy;

  // Ready comes from registered occupancy/state only, never from the sink's ready.
  assign in_enq_rdy  = ~w_full | (r_state == DISCARD);
  assign out_enq_ena = ~w_empty;
  assign out_enq_v   = w_empty ? '0 : r_q[r_rptr];

  always_comb begin
    w_base   = int'(r_count) * WIDTH;
    w_merged = r_asm;
    w_merged[w_base +: WIDTH] = in_enq_v;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= COLLECT;
      r_count <= '0;
      r_asm   <= '0;
    end else if (w_collect) begin
      if (w_push) begin
        // Clearing here keeps stale upper beats out of a later short message.
        r_count <= '0;
        r_asm   <= '0;
        if (w_overrun) begin
          r_state <= DISCARD;
        end
      end else begin
        r_count <= r_count + CW'(1);
        r_asm   <= w_merged;
      end
    end else if (w_accept && (r_state == DISCARD) && in_enq_last) begin
      r_state <= COLLECT;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (DEPTH == 1) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (DEPTH == 1) ? '0 : r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + OW'(1);
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - OW'(1);
      end
    end
  end

  // Payload storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q[r_wptr] <= w_merged[MSG_WIDTH-1:0];
    end
  end

`ifdef ADAPTER_ERRCNT_EN
  logic [15:0] r_err;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_err <= '0;
    end else if ((w_short || w_overrun) && (r_err != 16'hFFFF)) begin
      r_err <= r_err + 16'd1;
    end
  end

  assign err_count = r_err;
`endif

endmodule

// File: tb/tb_message_assembler.sv
// tb/tb_message_assembler.sv - scoreboard bench for message_assembler with a beat-list reference model.
module tb_message_assembler;

  localparam int WIDTH     = 32;
  localparam int MSG_WIDTH = 144;
  localparam int DEPTH     = 2;
  localparam int N         = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_ena = 1'b0;
  logic [WIDTH-1:0]     in_v = '0;
  logic                 in_last = 1'b0;
  logic                 out_rdy = 1'b1;
  logic                 in_rdy;
  logic                 out_ena;
  logic [MSG_WIDTH-1:0] out_v;
`ifdef ADAPTER_ERRCNT_EN
  logic [15:0]          err_count;
`endif

  message_assembler #(.WIDTH(WIDTH), .MSG_WIDTH(MSG_WIDTH), .DEPTH(DEPTH)) dut (
    .CLK         (clk),
    .nRST        (rst_n),
    .in_enq_ena  (in_ena),
    .in_enq_v    (in_v),
    .in_enq_last (in_last),
    .in_enq_rdy  (in_rdy),
    .out_enq_ena (out_ena),
    .out_enq_v   (out_v),
    .out_enq_rdy (out_rdy)
`ifdef ADAPTER_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [MSG_WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0]     beats[$];
  bit                   discard = 1'b0;
  int                   exp_err = 0;
  bit                   rand_rdy = 1'b0;

  task automatic check(input string name, input logic [MSG_WIDTH-1:0] act,
                       input logic [MSG_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a message is simply the list of beats laid side by side.
  function automatic void emit_message();
    logic [N*WIDTH-1:0] acc;
    acc = '0;
    for (int k = 0; k < beats.size(); k++) begin
      acc = acc | ({{(N*WIDTH-WIDTH){1'b0}}, beats[k]} << (k * WIDTH));
    end
    exp_q.push_back(acc[MSG_WIDTH-1:0]);
    beats.delete();
  endfunction

  function automatic void model_accept(input logic [WIDTH-1:0] v, input logic last);
    if (discard) begin
      if (last) discard = 1'b0;
      return;
    end
    beats.push_back(v);
    if (last) begin
      if (beats.size() < N && exp_err < 65535) exp_err++;
      emit_message();
    end else if (beats.size() == N) begin
      emit_message();
      discard = 1'b1;
      if (exp_err < 65535) exp_err++;
    end
  endfunction

  function automatic void model_reset();
    beats.delete();
    exp_q.delete();
    discard = 1'b0;
    exp_err = 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_ena && out_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_msg actual=%h required=none", out_v);
      end else begin
        check("msg_order", out_v, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] v, input logic last);
    bit acc;
    in_ena  = 1'b1;
    in_v    = v;
    in_last = last;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      acc = in_rdy;
      if (acc) model_accept(v, last);
      tick();
      if (acc) begin
        in_ena = 1'b0;
        return;
      end
    end
    in_ena = 1'b0;
    check("beat_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_msg(input int nb);
    for (int k = 0; k < nb; k++) send_beat($urandom, k == nb - 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_err(input string name);
`ifdef ADAPTER_ERRCNT_EN
    check(name, err_count, exp_err);
`else
    check(name, exp_q.size(), 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_ena", out_ena, 1'b0);
    check("reset_out_v", out_v, '0);
    check("reset_in_rdy", in_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_in_rdy", in_rdy, 1'b1);

    out_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) send_beat(32'h11111111 * k, 1'b0);
    check("nominal_no_early", out_ena, 1'b0);
    send_beat(32'h55555555, 1'b1);
    check("nominal_latency", out_ena, 1'b1);
    check("nominal_lo", out_v[31:0], 32'h11111111);
    check("nominal_hi", out_v[143:128], 16'h5555);
    tick();
    check("nominal_one_cycle", out_ena, 1'b0);
    drain();
    check_err("nominal_err");

    send_beat(32'hAAAAAAAA, 1'b0);
    send_beat(32'hBBBBBBBB, 1'b1);
    check("short_value", out_v, {80'h0, 32'hBBBBBBBB, 32'hAAAAAAAA});
    drain();
    check_err("short_err");

    for (int k = 1; k <= 7; k++) send_beat(32'h0C000000 + k, k == 7);
    drain();
    check_err("overrun_err");
    send_msg(5);
    drain();

    out_rdy = 1'b0;
    send_msg(5);
    send_msg(5);
    check("bp_full_rdy", in_rdy, 1'b0);
    check("bp_out_ena", out_ena, 1'b1);
    fork
      send_msg(5);
      begin
        repeat (3) tick();
        check("bp_hold_rdy", in_rdy, 1'b0);
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp_same_cycle_rdy", in_rdy, 1'b0);
        @(negedge clk);
        check("bp_release_rdy", in_rdy, 1'b1);
      end
    join
    drain();

    out_rdy = 1'b0;
    send_msg(2);
    for (int k = 0; k < 3; k++) send_beat(32'hDEAD0000 + k, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    check("midreset_out_ena", out_ena, 1'b0);
    check("midreset_in_rdy", in_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    out_rdy = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) send_beat(32'h70000000 + k, k == 5);
    drain();
    check_err("midreset_err");

    rand_rdy = 1'b1;
    for (int m = 0; m < 40; m++) begin
      int nb;
      nb = $urandom_range(1, 8);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send_beat($urandom, k == nb - 1);
      end
    end
    rand_rdy = 1'b0;
    out_rdy  = 1'b1;
    drain();
    check_err("random_err");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
